// File: rtl/pencoder.sv
// pencoder: priority encoder with registered outputs.
// Reports the index of the highest-numbered set bit of `in` on `out`.
// `valid` flags whether any bit was set. Latency is one cycle, and there
// is no combinational path from `in` to the outputs.
module pencoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic             valid
);

  // Reject parameter combinations that cannot encode every input index.
  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0 || OUT_W != $clog2(WIDTH)) begin : g_param_check
    $error("pencoder: WIDTH must be a power of two >= 2 and OUT_W must equal log2(WIDTH)");
  end

  logic [OUT_W-1:0] idx;
  logic             any;

  // Scan from the lowest bit upward so that the highest set bit is written last and wins.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (in[i]) idx = OUT_W'(i);
    end
    any = |in;
  end

  // Output register. Reset clears both outputs at once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out   <= '0;
      valid <= 1'b0;
    end else begin
      out   <= idx;
      valid <= any;
    end
  end

endmodule

// File: tb/tb_pencoder.sv
// tb_pencoder: self-checking bench for pencoder, checked against an arithmetic reference.
module tb_pencoder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned OUT_W = 3;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in;
  logic [OUT_W-1:0] out;
  logic             valid;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pencoder #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in),
    .out   (out),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the highest set bit equals floor(log2(v)), found by repeated halving.
  function automatic int unsigned ref_idx(input int unsigned v);
    int unsigned x;
    int unsigned n;
    x = v;
    n = 0;
    while (x > 1) begin
      x = x / 2;
      n++;
    end
    return n;
  endfunction

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int unsigned exp_out, input int unsigned exp_valid);
    check({tag, ".out"}, int'(out), exp_out);
    check({tag, ".valid"}, int'(valid), exp_valid);
  endtask

  // Drive v, capture it on the next edge, then check the registered result.
  task automatic step(input int unsigned v, input string tag);
    in = WIDTH'(v);
    @(posedge clk);
    #1;
    check_outs(tag, ref_idx(v), (v != 0) ? 1 : 0);
  endtask

  initial begin
    int unsigned v;
    rst = 1'b0;
    in  = 8'hFF;

    // Asynchronous reset, asserted before the first clock edge.
    #2 rst = 1'b1;
    #1 check_outs("reset_imm", 0, 0);
    repeat (2) @(posedge clk);
    #1 check_outs("reset_hold", 0, 0);
    rst = 1'b0;
    #1 check_outs("reset_release", 0, 0);
    @(posedge clk);
    #1 check_outs("first_capture_ff", 7, 1);

    // Multi-bit priority.
    step(8'b0011_0010, "prio_32");
    step(8'b0000_0101, "prio_05");

    // Single-bit sweep.
    for (int k = 0; k < 8; k++) step(1 << k, $sformatf("sweep_%0d", k));

    // Stable input held for four cycles.
    for (int c = 0; c < 4; c++) step(8'b0000_0010, $sformatf("hold_02_%0d", c));
    step(8'b0000_0001, "bit0");

    // Zero and boundary inputs.
    step(8'h00, "zero");
    step(8'h80, "top_bit");
    step(8'hFF, "all_ones");

    // Two input changes inside one cycle: only the final value is captured.
    in = 8'h01;
    #2 in = 8'h40;
    #1 check_outs("glitch_no_comb", 7, 1);
    @(posedge clk);
    #1 check_outs("glitch_capture", 6, 1);

    // Reset pulsed between edges, while out = 5 and valid = 1.
    step(8'b0011_0010, "pre_reset");
    #2 rst = 1'b1;
    #1 check_outs("mid_reset", 0, 0);
    rst = 1'b0;
    #1 check_outs("mid_reset_release", 0, 0);
    @(posedge clk);
    #1 check_outs("post_reset", 5, 1);

    // Randomised stream, with occasional mid-cycle reset pulses.
    for (int n = 0; n < 300; n++) begin
      v = $urandom_range(0, 255);
      if (($urandom % 20) == 0) begin
        in = WIDTH'(v);
        #2 rst = 1'b1;
        #1 check_outs("rand_reset", 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1 check_outs("rand_after_reset", ref_idx(v), (v != 0) ? 1 : 0);
      end else begin
        step(v, $sformatf("rand_%02h", v));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
